// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for DIV/DIVU.
//
// Takes a start request, latches both operands, then runs one restoring step per cycle for
// DATA_W cycles. The result is held, with ready_o set, until the requester drops start_i.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   signed_div_i 1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
//   opdata1_i    dividend; sampled with start_i
//   opdata2_i    divisor; sampled with start_i
//   start_i      request; held high until ready_o is seen, then dropped
//   annul_i      flush of an in-flight division (honoured in BYZERO and ON)
//   result_o     {remainder, quotient}; upper half to HI, lower half to LO
//   ready_o      result valid
//   dz_o         divisor was zero; valid while ready_o is high
//   busy_o       high in BYZERO and ON; used for stall generation
module div_iter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  dz_o,
    output logic                  busy_o
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] rem_q;      // partial remainder
    logic [DATA_W-1:0] dvd_q;      // dividend, shifted out as quotient bits shift in
    logic [DATA_W-1:0] dvs_q;      // divisor magnitude
    logic [CntW-1:0]   cnt_q;
    logic              neg_quo_q;
    logic              neg_rem_q;

    logic [DATA_W-1:0] abs1_d, abs2_d;
    logic              neg_quo_d, neg_rem_d;
    logic [DATA_W:0]   shifted_d, diff_d;
    logic [DATA_W-1:0] rem_step_d, dvd_step_d;
    logic [DATA_W-1:0] quo_fix_d, rem_fix_d;

    always_comb begin
        abs1_d    = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        abs2_d    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        neg_quo_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
        neg_rem_d = signed_div_i && opdata1_i[DATA_W-1];

        // rem < dvs < 2^DATA_W, so the shifted value fits DATA_W+1 bits and the MSB of the
        // wrapped difference is set exactly when the trial subtraction goes negative.
        shifted_d  = {rem_q, dvd_q[DATA_W-1]};
        diff_d     = shifted_d - {1'b0, dvs_q};
        rem_step_d = diff_d[DATA_W] ? shifted_d[DATA_W-1:0] : diff_d[DATA_W-1:0];
        dvd_step_d = {dvd_q[DATA_W-2:0], ~diff_d[DATA_W]};

        quo_fix_d = neg_quo_q ? -dvd_q : dvd_q;
        rem_fix_d = neg_rem_q ? -rem_q : rem_q;
    end

    assign busy_o = (state_q == StByZero) || (state_q == StOn);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
            dz_o      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_q <= StByZero;
                        end else begin
                            state_q   <= StOn;
                            dvd_q     <= abs1_d;
                            dvs_q     <= abs2_d;
                            rem_q     <= '0;
                            cnt_q     <= '0;
                            neg_quo_q <= neg_quo_d;
                            neg_rem_q <= neg_rem_d;
                        end
                    end
                end
                StByZero: begin
                    if (annul_i) begin
                        state_q <= StIdle;
                    end else begin
                        state_q  <= StEnd;
                        result_o <= '0;
                        dz_o     <= 1'b1;
                        ready_o  <= 1'b1;
                    end
                end
                StOn: begin
                    if (annul_i) begin
                        state_q <= StIdle;
                    end else if (cnt_q == CntW'(DATA_W)) begin
                        state_q  <= StEnd;
                        result_o <= {rem_fix_d, quo_fix_d};
                        dz_o     <= 1'b0;
                        ready_o  <= 1'b1;
                    end else begin
                        rem_q <= rem_step_d;
                        dvd_q <= dvd_step_d;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StEnd: begin
                    if (!start_i) begin
                        state_q  <= StIdle;
                        result_o <= '0;
                        dz_o     <= 1'b0;
                        ready_o  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: a 32-bit instance for the main vectors and an 8-bit
// instance for the width parameter. Expected values are hand-computed constants.
module tb_div_iter;

    logic        clk;
    logic        rst;

    logic        sgn32, start32, annul32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        rdy32, dz32, busy32;

    logic        sgn8, start8, annul8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        rdy8, dz8, busy8;

    int checks = 0;
    int errors = 0;

    div_iter #(.DATA_W(32)) u_dut32 (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sgn32),
        .opdata1_i    (a32),
        .opdata2_i    (b32),
        .start_i      (start32),
        .annul_i      (annul32),
        .result_o     (res32),
        .ready_o      (rdy32),
        .dz_o         (dz32),
        .busy_o       (busy32)
    );

    div_iter #(.DATA_W(8)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (sgn8),
        .opdata1_i    (a8),
        .opdata2_i    (b8),
        .start_i      (start8),
        .annul_i      (annul8),
        .result_o     (res8),
        .ready_o      (rdy8),
        .dz_o         (dz8),
        .busy_o       (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 32-bit transaction: start, scramble operands after the sampling edge, measure
    // latency and busy cycles, check result, hold, then drop start.
    task automatic run32(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input logic exp_dz, input int exp_lat);
        int n;
        int nbusy;
        sgn32   = sgn;
        a32     = a;
        b32     = b;
        start32 = 1'b1;
        tick();                       // E0 samples start
        a32   = $urandom;
        b32   = 32'd0;
        sgn32 = ~sgn;
        n     = 0;
        nbusy = 0;
        if (busy32) nbusy++;
        while (!rdy32 && n < 100) begin
            tick();
            n++;
            if (busy32) nbusy++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(nbusy), 64'(exp_lat));
        check({tag, " result"}, res32, exp_res);
        check({tag, " dz"}, {63'd0, dz32}, {63'd0, exp_dz});
        tick();
        check({tag, " held"}, {res32[62:0], rdy32}, {exp_res[62:0], 1'b1});
        start32 = 1'b0;
        tick();
        check({tag, " cleared"}, {res32[61:0], rdy32, dz32}, 64'd0);
    endtask

    initial begin
        sgn32 = 0; start32 = 0; annul32 = 0; a32 = 0; b32 = 0;
        sgn8  = 0; start8  = 0; annul8  = 0; a8  = 0; b8  = 0;
        rst = 1'b0;
        #23;
        check("reset32", {res32[60:0], rdy32, dz32, busy32}, 64'd0);
        check("reset8", {45'd0, res8, rdy8, dz8, busy8}, 64'd0);
        rst = 1'b1;
        tick();

        run32("u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 33);
        run32("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 33);
        run32("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0, 33);
        run32("u-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC}, 1'b0, 33);
        run32("div0", 1'b0, 32'd5, 32'd0, 64'd0, 1'b1, 1);
        run32("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, 33);
        run32("umax/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b0, 33);

        // Annul at cycle 10 of ON, then a fresh 9 / 3.
        begin
            int seen_rdy;
            seen_rdy = 0;
            sgn32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
            tick();
            for (int i = 0; i < 10; i++) begin
                tick();
                if (rdy32) seen_rdy++;
            end
            check("annul busy before", {63'd0, busy32}, 64'd1);
            annul32 = 1'b1;
            start32 = 1'b0;
            tick();
            if (rdy32) seen_rdy++;
            check("annul idle", {62'd0, busy32, rdy32}, 64'd0);
            annul32 = 1'b0;
            tick();
            if (rdy32) seen_rdy++;
            check("annul no ready", 64'(seen_rdy), 64'd0);
        end
        run32("u9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 33);

        // Annul in BYZERO returns to IDLE without a result.
        sgn32 = 1'b0; a32 = 32'd5; b32 = 32'd0; start32 = 1'b1;
        tick();
        annul32 = 1'b1;
        start32 = 1'b0;
        tick();
        check("annul byzero", {61'd0, busy32, rdy32, dz32}, 64'd0);
        annul32 = 1'b0;
        tick();

        // Reset mid-ON clears outputs immediately.
        sgn32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) tick();
        check("pre-reset busy", {63'd0, busy32}, 64'd1);
        rst = 1'b0;
        #1;
        check("async reset", {res32[60:0], rdy32, dz32, busy32}, 64'd0);
        start32 = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // DATA_W = 8: 200 / 13 -> q 15, r 5, ready after 9 edges.
        begin
            int n;
            sgn8 = 1'b0; a8 = 8'd200; b8 = 8'd13; start8 = 1'b1;
            tick();
            a8 = 8'd1; b8 = 8'd1;
            n = 0;
            while (!rdy8 && n < 50) begin
                tick();
                n++;
            end
            check("w8 latency", 64'(n), 64'd9);
            check("w8 result", {48'd0, res8}, {48'd0, 8'd5, 8'd15});
            check("w8 dz", {63'd0, dz8}, 64'd0);
            start8 = 1'b0;
            tick();
            check("w8 cleared", {46'd0, res8, rdy8, busy8}, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
